// File: rtl/scaler_cubic_filter_pkg.sv
// scaler_cubic_filter_pkg: width helpers and rounding constant shared across scaler stages.
// Revision 1.0 - initial release.
`default_nettype none

`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package scaler_cubic_filter_pkg;

  // Signed product of a zero-extended pixel and a signed coefficient.
  function automatic int prod_width(input int pix_w, input int coe_w);
    return pix_w + coe_w + 1;
  endfunction

  function automatic int pair_width(input int pix_w, input int coe_w);
    return prod_width(pix_w, coe_w) + 1;
  endfunction

  function automatic int total_width(input int pix_w, input int coe_w);
    return pair_width(pix_w, coe_w) + 1;
  endfunction

  function automatic int round_const(input int frac);
    return 1 << (frac - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/scaler_fifo.sv
// scaler_fifo: first-word-fall-through FIFO with occupancy count; head reads as zero when empty.
// Revision 1.0 - initial release.
`default_nettype none

module scaler_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign valid  = (count != '0);
  assign do_pop = pop && valid;
  assign dout   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_pop) count <= count + 1'b1;
      else if (!push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/scaler_cubic_filter.sv
// scaler_cubic_filter: 4-tap cubic interpolation MAC with round/clamp and credit-controlled output FIFO.
// Revision 1.0 - initial release.
`default_nettype none

module scaler_cubic_filter
  import scaler_cubic_filter_pkg::*;
#(
  parameter int PIX_WIDTH  = 8,
  parameter int COE_DEPTH  = 32,
  parameter int COE_WIDTH  = 10,
  parameter int COE_FRAC   = 8,
  parameter int USER_WIDTH = 2,
  parameter int FIFO_DEPTH = 8,
  localparam int PW        = `CLOG2(COE_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [4*PIX_WIDTH-1:0] s_pix,
  input  logic [PW-1:0]          s_phase,
  input  logic [USER_WIDTH-1:0]  s_user,
  output logic [PW-1:0]          coe_addr,
  input  logic [COE_WIDTH-1:0]   coe0,
  input  logic [COE_WIDTH-1:0]   coe1,
  input  logic [COE_WIDTH-1:0]   coe2,
  input  logic [COE_WIDTH-1:0]   coe3,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [PIX_WIDTH-1:0]   m_pix,
  output logic [USER_WIDTH-1:0]  m_user
);

  localparam int PROD_W = prod_width(PIX_WIDTH, COE_WIDTH);
  localparam int PAIR_W = pair_width(PIX_WIDTH, COE_WIDTH);
  localparam int TOT_W  = total_width(PIX_WIDTH, COE_WIDTH);
  localparam int ROUND  = round_const(COE_FRAC);
  localparam int FAW    = $clog2(FIFO_DEPTH);
  localparam int CW     = FAW + 2;

  logic                   accept;
  logic [3:0]             stage_v;
  logic [4*PIX_WIDTH-1:0] pix0, pix1;
  logic [USER_WIDTH-1:0]  user0, user1, user2, user3;
  logic [COE_WIDTH-1:0]   coe [4];
  logic signed [PROD_W-1:0] prod [4];
  logic signed [PAIR_W-1:0] sum01, sum23;
  logic signed [TOT_W-1:0]  total, rounded;
  logic [PIX_WIDTH-1:0]   clamped;
  logic [FAW:0]           fifo_count;
  logic [CW-1:0]          credit;

  assign accept = s_valid && s_ready;
  assign coe[0] = coe0;
  assign coe[1] = coe1;
  assign coe[2] = coe2;
  assign coe[3] = coe3;

  // Includes this cycle's acceptance; pops only free credit one cycle later.
  assign credit = {1'b0, fifo_count} + CW'(stage_v[0]) + CW'(stage_v[1])
                + CW'(stage_v[2]) + CW'(stage_v[3]) + CW'(accept);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_v  <= '0;
      coe_addr <= '0;
      s_ready  <= 1'b0;
    end else begin
      stage_v  <= {stage_v[2:0], accept};
      s_ready  <= (credit < CW'(FIFO_DEPTH));
      if (accept) coe_addr <= s_phase;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pix0  <= s_pix;
      user0 <= s_user;
    end
    pix1  <= pix0;
    user1 <= user0;
    user2 <= user1;
    user3 <= user2;
    sum01 <= PAIR_W'(prod[0]) + PAIR_W'(prod[1]);
    sum23 <= PAIR_W'(prod[2]) + PAIR_W'(prod[3]);
  end

  // ROM data is aligned with pix1 here, one edge after coe_addr was loaded.
  for (genvar i = 0; i < 4; i++) begin : g_mul
    always_ff @(posedge clk) begin
      prod[i] <= PROD_W'($signed({1'b0, pix1[i*PIX_WIDTH +: PIX_WIDTH]}))
               * PROD_W'($signed(coe[i]));
    end
  end

  always_comb begin
    total   = TOT_W'(sum01) + TOT_W'(sum23);
    rounded = (total + $signed(TOT_W'(ROUND))) >>> COE_FRAC;
    clamped = rounded[PIX_WIDTH-1:0];
    if (rounded[TOT_W-1]) clamped = '0;
    else if (|rounded[TOT_W-2:PIX_WIDTH]) clamped = '1;
  end

  scaler_fifo #(
    .WIDTH (USER_WIDTH + PIX_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (stage_v[3]),
    .din   ({user3, clamped}),
    .pop   (m_ready),
    .dout  ({m_user, m_pix}),
    .valid (m_valid),
    .count (fifo_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_scaler_cubic_filter.sv
// tb_scaler_cubic_filter: directed and randomized checks against a behavioural interpolation model.
// Revision 1.0 - initial release.
`default_nettype none

module tb_scaler_cubic_filter;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_pix = '0;
  logic [4:0]  s_phase = '0;
  logic [1:0]  s_user = '0;
  logic [4:0]  coe_addr;
  logic [9:0]  coe0, coe1, coe2, coe3;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [7:0]  m_pix;
  logic [1:0]  m_user;

  typedef struct {
    logic [7:0] pix;
    logic [1:0] user;
  } exp_t;

  exp_t exp_q[$];
  int   rom[32][4];
  int   checks = 0;
  int   errors = 0;
  logic acc_flag, pop_flag;
  int   pops;

  always #5 clk = ~clk;

  scaler_cubic_filter dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_pix(s_pix), .s_phase(s_phase), .s_user(s_user),
    .coe_addr(coe_addr), .coe0(coe0), .coe1(coe1), .coe2(coe2), .coe3(coe3),
    .m_valid(m_valid), .m_ready(m_ready), .m_pix(m_pix), .m_user(m_user)
  );

  // External coefficient ROM with a registered read port.
  always @(posedge clk) begin
    coe0 <= 10'(rom[coe_addr][0]);
    coe1 <= 10'(rom[coe_addr][1]);
    coe2 <= 10'(rom[coe_addr][2]);
    coe3 <= 10'(rom[coe_addr][3]);
  end

  function automatic logic [7:0] model(input logic [31:0] pix, input int phase);
    int sum = 0;
    int p, r;
    for (int i = 0; i < 4; i++) begin
      p = pix[8*i +: 8];
      sum += p * rom[phase][i];
    end
    r = (sum + 128) >>> 8;
    if (r < 0) r = 0;
    if (r > 255) r = 255;
    return 8'(r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    exp_t e;
    @(negedge clk);
    acc_flag = s_valid && s_ready;
    pop_flag = m_valid && m_ready;
    if (acc_flag) begin
      e.pix  = model(s_pix, int'(s_phase));
      e.user = s_user;
      exp_q.push_back(e);
    end
    if (pop_flag) begin
      pops++;
      if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("m_pix", m_pix, e.pix);
        chk("m_user", m_user, e.user);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] p0, p1, p2, p3, input int ph, input logic [1:0] u);
    s_pix   = {p3, p2, p1, p0};
    s_phase = 5'(ph);
    s_user  = u;
    s_valid = 1'b1;
  endtask

  task automatic send(input logic [7:0] p0, p1, p2, p3, input int ph, input logic [1:0] u);
    bit done = 0;
    drive(p0, p1, p2, p3, ph, u);
    for (int i = 0; i < 50 && !done; i++) begin
      cycle();
      done = acc_flag;
    end
    s_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20 && !m_valid; i++) cycle();
    if (!m_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic directed(input logic [7:0] p0, p1, p2, p3, input int ph, input logic [7:0] exp, input string tag);
    m_ready = 1'b0;
    send(p0, p1, p2, p3, ph, 2'd2);
    wait_valid();
    chk(tag, m_pix, exp);
    m_ready = 1'b1;
    cycle();
    m_ready = 1'b0;
  endtask

  task automatic drain();
    m_ready = 1'b1;
    s_valid = 1'b0;
    for (int i = 0; i < 60 && (exp_q.size() != 0 || m_valid); i++) cycle();
    chk("drain_left", exp_q.size(), 0);
    chk("drain_m_valid", m_valid, 0);
  endtask

  initial begin
    int c0, c1, c3, accepted;
    for (int ph = 0; ph < 32; ph++) begin
      c0 = -int'($urandom_range(32));
      c3 = -int'($urandom_range(32));
      c1 = int'($urandom_range(256));
      rom[ph] = '{c0, c1, 256 - c0 - c1 - c3, c3};
    end
    rom[0]  = '{0, 256, 0, 0};
    rom[16] = '{-16, 144, 144, -16};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_coe_addr", coe_addr, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_pix", m_pix, 0);
    chk("rst_m_user", m_user, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_release", s_ready, 1);

    // Identity taps with latency check.
    drive(10, 20, 30, 40, 0, 2'd1);
    cycle();
    s_valid = 1'b0;
    chk("identity_accept", acc_flag, 1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("latency_early", m_valid, 0);
    end
    cycle();
    chk("latency_valid", m_valid, 1);
    chk("identity_pix", m_pix, 20);
    chk("identity_user", m_user, 1);
    m_ready = 1'b1;
    cycle();
    m_ready = 1'b0;

    directed(0, 100, 100, 0, 16, 113, "midpoint");
    chk("coe_addr_hold", coe_addr, 16);
    directed(0, 255, 255, 0, 16, 255, "clamp_high");
    directed(255, 0, 0, 255, 16, 0, "clamp_low");

    // Backpressure: exactly DEPTH beats fit.
    m_ready = 1'b0;
    accepted = 0;
    drive(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(31)), 2'($urandom));
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (acc_flag) begin
        accepted++;
        drive(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(31)), 2'($urandom));
      end
    end
    s_valid = 1'b0;
    chk("bp_accepted", accepted, DEPTH);
    chk("bp_s_ready", s_ready, 0);
    pops = 0;
    drain();
    chk("bp_pops", pops, DEPTH);

    // Back-to-back phases at full throughput.
    m_ready = 1'b1;
    pops = 0;
    for (int ph = 0; ph < 32; ph++) begin
      chk("b2b_s_ready", s_ready, 1);
      drive(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), ph, 2'($urandom));
      cycle();
      chk("b2b_accept", acc_flag, 1);
    end
    s_valid = 1'b0;
    repeat (5) cycle();
    chk("b2b_pops", pops, 32);
    drain();

    // Reset with 3 beats in flight and 2 buffered.
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(31)), 2'($urandom));
      cycle();
    end
    s_valid = 1'b0;
    cycle();
    chk("pre_reset_valid", m_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_m_valid", m_valid, 0);
    chk("reset_coe_addr", coe_addr, 0);
    chk("reset_s_ready", s_ready, 0);
    exp_q.delete();
    repeat (2) cycle();
    rst_n = 1'b1;
    m_ready = 1'b1;
    pops = 0;
    repeat (8) cycle();
    chk("no_stale_output", pops, 0);
    send(50, 60, 70, 80, 0, 2'd3);
    drain();
    chk("post_reset_pops", pops, 1);

    // Randomized traffic with random backpressure.
    s_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!s_valid || acc_flag) begin
        drive(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(31)), 2'($urandom));
        s_valid = ($urandom_range(3) != 0);
      end
      m_ready = ($urandom_range(2) != 0);
      cycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/scaler_cubic_filter.md
Name: scaler_cubic_filter

Overview:
- 4-tap cubic interpolation datapath directly downstream of the scaler's 4-bank coefficient ROM.
- Accepts a 4-pixel source window plus phase per output sample and drives the phase as the ROM address.
- Aligns the window with the registered ROM outputs, then multiply-accumulates, rounds and clamps.
- Buffers results in an output FIFO; input backpressure is credit based, so the pipeline itself never stalls.

Parameters:
- PIX_WIDTH, 8: unsigned pixel width.
- COE_DEPTH, 32: coefficient ROM depth; phase width PW = `CLOG2(COE_DEPTH).
- COE_WIDTH, 10: signed two's-complement coefficient width.
- COE_FRAC, 8: coefficient fraction bits; the taps of one phase sum to 1<<COE_FRAC.
- USER_WIDTH, 2: sideband (sof/eol) carried alongside each sample.
- FIFO_DEPTH, 8: output FIFO entries; power of 2, minimum 8.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid&&s_ready at clk edge.
- s_pix  in  4*PIX_WIDTH  window, p0 in LSBs to p3 in MSBs.
- s_phase  in  PW  interpolation phase.
- s_user  in  USER_WIDTH  sideband.
- coe_addr  out  PW  ROM address; registered.
- coe0..coe3  in  COE_WIDTH each  ROM data, valid one edge after coe_addr.
- m_valid  out  1  output sample valid (FIFO not empty).
- m_ready  in  1  downstream accept.
- m_pix  out  PIX_WIDTH  interpolated pixel.
- m_user  out  USER_WIDTH  sideband of the same beat.

Behaviour:
- Reset values, all asynchronous: s_ready=0 while rst_n=0, then 1 from the first cycle after release. coe_addr=0, m_valid=0, m_pix=0, m_user=0. All stage valid bits, FIFO pointers and counts are 0.
- Pipeline runs free every cycle and carries a valid bit per stage.
- S0, accept edge N: capture window and user; coe_addr<=s_phase only on acceptance, otherwise hold.
- S1, edge N+1: ROM outputs now belong to the beat; delay window and user one stage so they align with coe0..3.
- S2, edge N+2: four products p_i (zero-extended to signed) * coe_i, each PIX_WIDTH+COE_WIDTH+1 bits.
- S3, edge N+3: pairwise sums (p0+p1), (p2+p3), +1 bit.
- S4, edge N+4:
  - total sum, +1 bit;
  - add 1<<(COE_FRAC-1), then arithmetic shift right by COE_FRAC;
  - clamp below 0 to 0 and above 2^PIX_WIDTH-1 to 2^PIX_WIDTH-1;
  - write result and user to the FIFO.
- Latency: beat accepted at edge N is written to the FIFO at edge N+4. With an empty FIFO, m_valid is high after edge N+4 (4 cycles).
- Credit: inflight = count of valid bits in S0..S3. s_ready = (fifo_count + inflight) < FIFO_DEPTH, registered, so conservative by one cycle. FIFO overflow is impossible by construction.
- FIFO:
  - first-word-fall-through; m_pix/m_user show the head entry while m_valid=1;
  - pop on m_valid&&m_ready;
  - simultaneous push and pop leaves the count unchanged;
  - pointers wrap modulo FIFO_DEPTH;
  - a pop when empty is ignored.
- Ordering is strictly preserved; sideband travels unmodified with its sample.
- Reset mid-operation: all in-flight and buffered samples are discarded with no partial output, and coe_addr returns to 0.
- s_valid while s_ready=0: no state change; upstream must hold the beat.

Decomposition:
- user_pkg.v: `CLOG2 macro, plus localparams for product/sum widths and the rounding constant, shared with other scaler stages.
- One sub-module, scaler_fifo: synchronous FWFT FIFO with async active-low reset; parameters WIDTH and DEPTH; exposes count.
- The coefficient ROM stays external and is connected at the scaler top.

Test Plan:
- Identity taps: bench ROM phase 0 = (0,256,0,0); window (10,20,30,40), phase 0 -> m_pix=20, m_valid 4 cycles after acceptance.
- Midpoint: phase 16 = (-16,144,144,-16); window (0,100,100,0) -> m_pix=113 (28800+128>>8, rounded).
- Clamp: window (0,255,255,0), phase 16 -> sum 73440 -> m_pix=255. Window (255,0,0,255), phase 16 -> negative -> m_pix=0.
- Backpressure: m_ready=0, s_valid=1 continuously -> exactly FIFO_DEPTH beats accepted and s_ready=0. Release m_ready -> all samples out in order, none lost or duplicated.
- Back-to-back phases: consecutive beats with phases 0,1,2,...,31, m_ready=1 -> each output uses its own phase's taps, 1 sample per cycle, s_ready stays 1.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight and 2 in the FIFO -> m_valid=0 immediately; after release there is no stale output, and the first new beat is correct.
